vga_raster_gen: RTL and testbench
=================================

# vga_raster_gen

Generates the 640x480@60 Hz raster for the display path: the current pixel coordinate, six look-ahead coordinate pairs for pipelined sprite/ROM fetch, the active-video flag, and HSYNC/VSYNC. It drives the `h_cnt*`/`v_cnt*`/`valid` inputs consumed by the render stage. It compensates the render stage's registered RGB output so that sync and pixels leave the board aligned.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, HSYNC width
- H_BP, 48, horizontal back porch (H_TOTAL = 800)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, VSYNC width
- V_BP, 33, vertical back porch (V_TOTAL = 525)
- SYNC_LAG, 1, extra cycles of delay on hsync/vsync; legal range 0..3

Ports:
- clk  in  1  25 MHz pixel clock; the only clock
- rst  in  1  asynchronous, active-low reset
- h_cnt  out  10  current pixel column, 0..H_TOTAL-1
- v_cnt  out  10  current line, 0..V_TOTAL-1
- h_cnt_1..h_cnt_6  out  10 each  column the raster reaches k cycles later
- v_cnt_1..v_cnt_6  out  10 each  line the raster reaches k cycles later
- valid  out  1  high while (h_cnt, v_cnt) is in the visible region
- hsync  out  1  active-low horizontal sync, delayed SYNC_LAG cycles
- vsync  out  1  active-low vertical sync, delayed SYNC_LAG cycles
- frame_start  out  1  one-cycle pulse while h_cnt=0 and v_cnt=0

## Operation
- The master counter pair is (h_cnt_6, v_cnt_6).
  - Each cycle h increments. At H_TOTAL-1 it wraps to 0.
  - v increments only on an h wrap. It wraps from V_TOTAL-1 to 0.
- Delay chain: h_cnt_5 <= h_cnt_6, ..., h_cnt_1 <= h_cnt_2, h_cnt <= h_cnt_1. The v chain is identical.
  - Invariant: h_cnt_k and v_cnt_k always equal (h_cnt, v_cnt) advanced k raster positions, including across line and frame wrap.
- Registered flags computed from (h_cnt_1, v_cnt_1), so they are coincident with h_cnt/v_cnt:
  - valid = (h < H_VIS) && (v < V_VIS)
  - frame_start = (h == 0) && (v == 0)
  - raw hsync low for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC, i.e. 656..751
  - raw vsync low for V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC, i.e. 490..491
- Output hsync/vsync: raw values passed through a SYNC_LAG-deep shift register. SYNC_LAG=0 means raw values directly.
- Widths: all counters are 10-bit unsigned. The comparison constants derive from the parameters; no arithmetic overflow is possible for the defaults.

## Timing
- Reset values while rst=0:
  - h_cnt=0, v_cnt=0
  - h_cnt_k=k and v_cnt_k=0, for k=1..6
  - valid=0, frame_start=0, hsync=1, vsync=1, all sync delay stages=1
- First rising edge after release:
  - h_cnt=1, h_cnt_6=7
  - valid=1, because it was computed from h_cnt_1=1
  - Consequence: pixel (0,0) of the first frame only is blanked, and frame_start does not fire until the second frame.
- Latency:
  - h_cnt_k leads h_cnt by exactly k cycles.
  - valid and frame_start have zero lag relative to h_cnt/v_cnt.
  - hsync/vsync lag h_cnt by SYNC_LAG cycles. The default of 1 matches the render stage's output register.
- Line timing:
  - Line period is 800 cycles; frame period is 420000 cycles.
  - hsync is low for 96 consecutive cycles per line.
  - vsync is low for 1600 consecutive cycles per frame.
- Reset asserted mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge. The raster restarts from (0,0) on release.
- There are no stall or enable inputs; the raster is free-running.

## Test plan
- Reset release: hold rst=0 for 5 cycles, then release.
  - During reset: h_cnt=0, h_cnt_6=6, hsync=vsync=1, valid=0.
  - Edge 1: h_cnt=1, valid=1.
- Line wrap: run to h_cnt=799, v_cnt=0.
  - That cycle: h_cnt_1=0 and v_cnt_1=1; h_cnt_6=5 and v_cnt_6=1.
  - Next cycle: h_cnt=0, v_cnt=1.
- Frame wrap: at h_cnt=799, v_cnt=524, check h_cnt_1=0 and v_cnt_1=0.
  - Next cycle: frame_start=1 for exactly one cycle.
  - Frame-to-frame period: 420000 cycles.
- Sync windows with SYNC_LAG=1:
  - hsync falls 1 cycle after h_cnt=656 and rises 1 cycle after h_cnt=752, i.e. 96 cycles low.
  - vsync is low exactly while v_cnt is delayed-in 490..491.
  - Repeat with SYNC_LAG=0 and SYNC_LAG=3; edges shift accordingly.
- Valid window: valid rises at h_cnt=0 and falls at h_cnt=640 on lines 0..479. valid=0 on every pixel of lines 480..524.
- Mid-frame reset: pulse rst=0 asynchronously (between edges) at v_cnt=300, h_cnt=400.
  - Outputs take their reset values within the same cycle.
  - After release, counting restarts at h_cnt=1 and v_cnt=0.

Source files
------------

// File: rtl/vga_raster_gen.sv
// vga_raster_gen: 640x480@60 raster timing with six-deep look-ahead
// coordinates, coincident active/frame flags and lag-matched active-low syncs.
module vga_raster_gen #(
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_LAG = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic [9:0] h_cnt_1,
  output logic [9:0] h_cnt_2,
  output logic [9:0] h_cnt_3,
  output logic [9:0] h_cnt_4,
  output logic [9:0] h_cnt_5,
  output logic [9:0] h_cnt_6,
  output logic [9:0] v_cnt_1,
  output logic [9:0] v_cnt_2,
  output logic [9:0] v_cnt_3,
  output logic [9:0] v_cnt_4,
  output logic [9:0] v_cnt_5,
  output logic [9:0] v_cnt_6,
  output logic       valid,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DEPTH    = 6;
  localparam int unsigned H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VIS + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VIS + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // Index k holds the coordinate k cycles ahead; index DEPTH is the master counter.
  logic [CW-1:0] h_pipe [0:DEPTH];
  logic [CW-1:0] v_pipe [0:DEPTH];
  logic [CW-1:0] h_next_c;
  logic [CW-1:0] v_next_c;
  logic          hs_raw;
  logic          vs_raw;

  // Next raster position of the master counter pair.
  always_comb begin
    h_next_c = h_pipe[DEPTH] + CW'(1);
    v_next_c = v_pipe[DEPTH];
    if (h_pipe[DEPTH] == CW'(H_TOTAL - 1)) begin
      h_next_c = '0;
      if (v_pipe[DEPTH] == CW'(V_TOTAL - 1)) begin
        v_next_c = '0;
      end else begin
        v_next_c = v_pipe[DEPTH] + CW'(1);
      end
    end
  end

  // Master counter plus delay chain; reset preloads each stage k positions ahead of (0,0).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= int'(DEPTH); k++) begin
        h_pipe[k] <= CW'(k);
        v_pipe[k] <= '0;
      end
    end else begin
      h_pipe[DEPTH] <= h_next_c;
      v_pipe[DEPTH] <= v_next_c;
      for (int k = 0; k < int'(DEPTH); k++) begin
        h_pipe[k] <= h_pipe[k+1];
        v_pipe[k] <= v_pipe[k+1];
      end
    end
  end

  // Flags decoded one position early so they register coincident with h_cnt/v_cnt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid       <= 1'b0;
      frame_start <= 1'b0;
      hs_raw      <= 1'b1;
      vs_raw      <= 1'b1;
    end else begin
      valid       <= (h_pipe[1] < CW'(H_VIS)) && (v_pipe[1] < CW'(V_VIS));
      frame_start <= (h_pipe[1] == '0) && (v_pipe[1] == '0);
      hs_raw      <= !((h_pipe[1] >= CW'(HS_START)) && (h_pipe[1] < CW'(HS_END)));
      vs_raw      <= !((v_pipe[1] >= CW'(VS_START)) && (v_pipe[1] < CW'(VS_END)));
    end
  end

  generate
    if (SYNC_LAG == 0) begin : g_no_lag
      assign hsync = hs_raw;
      assign vsync = vs_raw;
    end else begin : g_lag
      logic [SYNC_LAG-1:0] hs_dly;
      logic [SYNC_LAG-1:0] vs_dly;

      // Sync delay line matching the render stage's pixel output register(s).
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hs_dly <= '1;
          vs_dly <= '1;
        end else begin
          hs_dly <= SYNC_LAG'({hs_dly, hs_raw});
          vs_dly <= SYNC_LAG'({vs_dly, vs_raw});
        end
      end

      assign hsync = hs_dly[SYNC_LAG-1];
      assign vsync = vs_dly[SYNC_LAG-1];
    end
  endgenerate

  assign h_cnt   = h_pipe[0];
  assign h_cnt_1 = h_pipe[1];
  assign h_cnt_2 = h_pipe[2];
  assign h_cnt_3 = h_pipe[3];
  assign h_cnt_4 = h_pipe[4];
  assign h_cnt_5 = h_pipe[5];
  assign h_cnt_6 = h_pipe[6];
  assign v_cnt   = v_pipe[0];
  assign v_cnt_1 = v_pipe[1];
  assign v_cnt_2 = v_pipe[2];
  assign v_cnt_3 = v_pipe[3];
  assign v_cnt_4 = v_pipe[4];
  assign v_cnt_5 = v_pipe[5];
  assign v_cnt_6 = v_pipe[6];

endmodule

// File: tb/tb_vga_raster_gen.sv
// tb_vga_raster_gen: scoreboard bench; expectations are queued by cycle tag,
// a monitor pops and compares them against four raster instances.
`timescale 1ns/1ps
module tb_vga_raster_gen;

  localparam int NINST = 4;  // 0: lag1, 1: lag0, 2: lag3, 3: small raster lag1
  localparam int EP    = 1000000;

  // signal codes: 0..6 h_cnt_k (k=0 is h_cnt), 7..13 v_cnt_k, 14 valid, 15 hsync, 16 vsync, 17 frame_start
  localparam int S_VALID = 14;
  localparam int S_HS    = 15;
  localparam int S_VS    = 16;
  localparam int S_FS    = 17;
  localparam int NSIG    = 18;

  typedef struct {
    int tag;
    int id;
    int exp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [9:0] hk [NINST][7];
  logic [9:0] vk [NINST][7];
  logic       vld [NINST];
  logic       hs  [NINST];
  logic       vs  [NINST];
  logic       fs  [NINST];

  exp_t q[$];
  int   total;
  int   bad;
  int   cyc;
  int   epoch;
  bit   started;
  event chk_ev;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    vga_raster_gen #(
      .H_VIS   (g == 3 ? 8 : 640),
      .H_FP    (g == 3 ? 2 : 16),
      .H_SYNC  (g == 3 ? 3 : 96),
      .H_BP    (g == 3 ? 3 : 48),
      .V_VIS   (g == 3 ? 4 : 480),
      .V_FP    (g == 3 ? 1 : 10),
      .V_SYNC  (2),
      .V_BP    (g == 3 ? 2 : 33),
      .SYNC_LAG(g == 1 ? 0 : (g == 2 ? 3 : 1))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .h_cnt      (hk[g][0]),
      .v_cnt      (vk[g][0]),
      .h_cnt_1    (hk[g][1]),
      .h_cnt_2    (hk[g][2]),
      .h_cnt_3    (hk[g][3]),
      .h_cnt_4    (hk[g][4]),
      .h_cnt_5    (hk[g][5]),
      .h_cnt_6    (hk[g][6]),
      .v_cnt_1    (vk[g][1]),
      .v_cnt_2    (vk[g][2]),
      .v_cnt_3    (vk[g][3]),
      .v_cnt_4    (vk[g][4]),
      .v_cnt_5    (vk[g][5]),
      .v_cnt_6    (vk[g][6]),
      .valid      (vld[g]),
      .hsync      (hs[g]),
      .vsync      (vs[g]),
      .frame_start(fs[g])
    );
  end

  // 25 MHz pixel clock
  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  // Edges since the most recent reset release
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  function automatic int sid(input int inst, input int s);
    return inst * 32 + s;
  endfunction

  function automatic string nm(input int id);
    string inst_s;
    string sig_s;
    int    s;
    s = id % 32;
    case (id / 32)
      0:       inst_s = "lag1";
      1:       inst_s = "lag0";
      2:       inst_s = "lag3";
      default: inst_s = "small";
    endcase
    if (s == 0)            sig_s = "h_cnt";
    else if (s <= 6)       sig_s = $sformatf("h_cnt_%0d", s);
    else if (s == 7)       sig_s = "v_cnt";
    else if (s <= 13)      sig_s = $sformatf("v_cnt_%0d", s - 7);
    else if (s == S_VALID) sig_s = "valid";
    else if (s == S_HS)    sig_s = "hsync";
    else if (s == S_VS)    sig_s = "vsync";
    else                   sig_s = "frame_start";
    return {inst_s, ".", sig_s};
  endfunction

  function automatic int actual(input int id);
    int inst;
    int s;
    inst = id / 32;
    s    = id % 32;
    if (s <= 6)       return int'(hk[inst][s]);
    if (s <= 13)      return int'(vk[inst][s-7]);
    if (s == S_VALID) return int'(vld[inst]);
    if (s == S_HS)    return int'(hs[inst]);
    if (s == S_VS)    return int'(vs[inst]);
    return int'(fs[inst]);
  endfunction

  // Reference: n edges after release the raster sits at position n of the frame
  function automatic int model(input int inst, input int s, input int n);
    int ht, vt, hv, vv, hs0, hs1, vs0, vs1, lag, h, v, m;
    if (inst == 3) begin
      ht = 16;  vt = 9;   hv = 8;   vv = 4;   hs0 = 10;  hs1 = 13;  vs0 = 5;   vs1 = 7;
    end else begin
      ht = 800; vt = 525; hv = 640; vv = 480; hs0 = 656; hs1 = 752; vs0 = 490; vs1 = 492;
    end
    lag = (inst == 1) ? 0 : ((inst == 2) ? 3 : 1);
    if (s <= 6)  return (n + s) % ht;
    if (s <= 13) return ((n + s - 7) / ht) % vt;
    h = n % ht;
    v = (n / ht) % vt;
    if (s == S_VALID) return int'(n > 0 && h < hv && v < vv);
    if (s == S_FS)    return int'(n > 0 && h == 0 && v == 0);
    m = n - lag;
    if (m < 0) return 1;
    if (s == S_HS) return int'(!((m % ht) >= hs0 && (m % ht) < hs1));
    return int'(!(((m / ht) % vt) >= vs0 && ((m / ht) % vt) < vs1));
  endfunction

  task automatic push(input int tag, input int inst, input int s, input int e);
    exp_t x;
    x.tag = tag;
    x.id  = sid(inst, s);
    x.exp = e;
    q.push_back(x);
  endtask

  // Queue every expectation for cycles 0..nmax of an epoch, in cycle order
  task automatic push_epoch(input int ep, input int nmax);
    int t;
    for (int n = 0; n <= nmax; n++) begin
      t = ep * EP + n;
      for (int i = 0; i < NINST; i++)
        for (int s = 0; s < NSIG; s++)
          push(t, i, s, model(i, s, n));
      if (ep == 0) begin
        case (n)
          0: begin
            push(t, 0, 6, 6); push(t, 0, 1, 1); push(t, 0, 13, 0); push(t, 0, S_VALID, 0);
            push(t, 0, S_FS, 0); push(t, 0, S_HS, 1); push(t, 0, S_VS, 1); push(t, 3, 6, 6);
          end
          1:   begin push(t, 0, 0, 1); push(t, 0, 6, 7); push(t, 0, S_VALID, 1); end
          80:  push(t, 3, S_VS, 1);
          81:  push(t, 3, S_VS, 0);
          112: push(t, 3, S_VS, 0);
          113: push(t, 3, S_VS, 1);
          143: begin push(t, 3, 1, 0); push(t, 3, 8, 0); push(t, 3, S_FS, 0); end
          144: begin push(t, 3, S_FS, 1); push(t, 3, 0, 0); push(t, 3, 7, 0); end
          145: push(t, 3, S_FS, 0);
          288: push(t, 3, S_FS, 1);
          639: push(t, 0, S_VALID, 1);
          640: push(t, 0, S_VALID, 0);
          655: push(t, 1, S_HS, 1);
          656: begin push(t, 1, S_HS, 0); push(t, 0, S_HS, 1); end
          657: push(t, 0, S_HS, 0);
          658: push(t, 2, S_HS, 1);
          659: push(t, 2, S_HS, 0);
          751: push(t, 1, S_HS, 0);
          752: begin push(t, 1, S_HS, 1); push(t, 0, S_HS, 0); end
          753: push(t, 0, S_HS, 1);
          754: push(t, 2, S_HS, 0);
          755: push(t, 2, S_HS, 1);
          799: begin
            push(t, 0, 0, 799); push(t, 0, 7, 0); push(t, 0, 1, 0); push(t, 0, 8, 1);
            push(t, 0, 6, 5); push(t, 0, 13, 1);
          end
          800: begin push(t, 0, 0, 0); push(t, 0, 7, 1); push(t, 0, S_VALID, 1); end
          default: ;
        endcase
      end else begin
        case (n)
          0: begin
            push(t, 0, 0, 0); push(t, 0, 6, 6); push(t, 0, S_VALID, 0); push(t, 0, S_HS, 1);
            push(t, 3, S_VALID, 0); push(t, 3, 0, 0); push(t, 3, 7, 0);
          end
          1: begin push(t, 0, 0, 1); push(t, 0, 7, 0); push(t, 3, 0, 1); push(t, 3, 7, 0); end
          default: ;
        endcase
      end
    end
  endtask

  // Monitor: pop and compare all expectations due at the current tag
  task automatic sample();
    int   cur;
    int   a;
    exp_t e;
    cur = epoch * EP + cyc;
    while (q.size() > 0 && q[0].tag <= cur) begin
      e = q.pop_front();
      total++;
      if (e.tag < cur) begin
        bad++;
        $display("FAIL %s tag=%0d never sampled (now %0d) required=%0d", nm(e.id), e.tag, cur, e.exp);
      end else begin
        a = actual(e.id);
        if (a != e.exp) begin
          bad++;
          $display("FAIL %s tag=%0d actual=%0d required=%0d", nm(e.id), e.tag, a, e.exp);
        end
      end
    end
  endtask

  initial begin
    wait (started);
    forever begin
      @(negedge clk or chk_ev);
      sample();
    end
  end

  initial begin
    #(5000 * 40);
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Stimulus: reset, free run, asynchronous mid-frame reset, restart
  initial begin
    total   = 0;
    bad     = 0;
    epoch   = 0;
    started = 1'b0;
    rst     = 1'b0;
    push_epoch(0, 1637);
    repeat (2) @(posedge clk);
    started = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    wait (cyc == 1637);
    @(negedge clk);
    #5 rst = 1'b0;
    #1;
    epoch = 1;
    push_epoch(1, 20);
    ->chk_ev;
    #1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;

    wait (cyc == 22);
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s tag=%0d left unchecked", nm(q[0].id), q[0].tag);
      void'(q.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
